// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// per-register busy scoreboard. ALU and MEM producers are served round-robin.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_alu_valid,
    output logic                o_alu_ready,
    input  logic [ADDR_W-1:0]   i_alu_addr,
    input  logic [DATA_W-1:0]   i_alu_data,
    input  logic                i_mem_valid,
    output logic                o_mem_ready,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_data,
    output logic                o_regWrite_en,
    output logic [ADDR_W-1:0]   o_write_addr,
    output logic [DATA_W-1:0]   o_write_reg_data,
    input  logic                i_issue_valid,
    input  logic [ADDR_W-1:0]   i_issue_addr,
    input  logic [ADDR_W-1:0]   i_read_1_addr,
    input  logic [ADDR_W-1:0]   i_read_2_addr,
    output logic                o_rd1_busy,
    output logic                o_rd2_busy,
    output logic [NUM_REGS-1:0] o_busy_bits
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    src_e                r_last_grant;
    logic                r_we;
    wb_req_t             r_wb;
    logic [NUM_REGS-1:0] r_busy;

    logic                w_grant_alu;
    logic                w_grant_mem;
    logic                w_hs;
    wb_req_t             w_sel;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // ALU wins a contended cycle only if MEM was served last.
    assign w_grant_alu = !i_rst && i_alu_valid && (!i_mem_valid || r_last_grant == SRC_MEM);
    assign w_grant_mem = !i_rst && i_mem_valid && !w_grant_alu;
    assign w_hs        = w_grant_alu || w_grant_mem;
    assign w_sel       = w_grant_alu ? wb_req_t'{i_alu_addr, i_alu_data}
                                     : wb_req_t'{i_mem_addr, i_mem_data};

    assign o_alu_ready = w_grant_alu;
    assign o_mem_ready = w_grant_mem;

    // Issue-set has priority over commit-clear on the same register; reg 0 never busy.
    assign w_busy_nxt[0] = 1'b0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_busy
        logic w_set;
        logic w_clr;
        assign w_set         = i_issue_valid && (i_issue_addr == ADDR_W'(g));
        assign w_clr         = r_we && (r_wb.addr == ADDR_W'(g));
        assign w_busy_nxt[g] = w_set || (r_busy[g] && !w_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= SRC_MEM;
            r_we         <= 1'b0;
            r_wb         <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_hs && (w_sel.addr != '0);
            if (w_hs) begin
                r_last_grant <= w_grant_alu ? SRC_ALU : SRC_MEM;
            end
            // Writes to register 0 are swallowed; the output bus keeps its last value.
            if (w_hs && (w_sel.addr != '0)) begin
                r_wb <= w_sel;
            end
        end
    end

    assign o_regWrite_en    = r_we;
    assign o_write_addr     = r_wb.addr;
    assign o_write_reg_data = r_wb.data;
    assign o_busy_bits      = r_busy;
    assign o_rd1_busy       = r_busy[i_read_1_addr];
    assign o_rd2_busy       = r_busy[i_read_2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake latency, round-robin,
// scoreboard set/clear priority, register-0 handling and mid-stream reset.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_alu_valid, i_mem_valid, i_issue_valid;
    logic                o_alu_ready, o_mem_ready;
    logic [ADDR_W-1:0]   i_alu_addr, i_mem_addr, i_issue_addr, i_read_1_addr, i_read_2_addr;
    logic [DATA_W-1:0]   i_alu_data, i_mem_data;
    logic                o_regWrite_en, o_rd1_busy, o_rd2_busy;
    logic [ADDR_W-1:0]   o_write_addr;
    logic [DATA_W-1:0]   o_write_reg_data;
    logic [NUM_REGS-1:0] o_busy_bits;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .o_regWrite_en(o_regWrite_en), .o_write_addr(o_write_addr),
        .o_write_reg_data(o_write_reg_data),
        .i_issue_valid(i_issue_valid), .i_issue_addr(i_issue_addr),
        .i_read_1_addr(i_read_1_addr), .i_read_2_addr(i_read_2_addr),
        .o_rd1_busy(o_rd1_busy), .o_rd2_busy(o_rd2_busy), .o_busy_bits(o_busy_bits)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs then change, outputs settle.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_alu_valid = 1'b1; i_alu_addr = 5'd9; i_alu_data = 64'd1;
        i_mem_valid = 1'b0; i_mem_addr = '0;   i_mem_data = '0;
        i_issue_valid = 1'b0; i_issue_addr = '0;
        i_read_1_addr = '0; i_read_2_addr = '0;

        // Reset: no grant while rst is high, outputs cleared
        tick(); tick();
        chk("rst_alu_ready", o_alu_ready, 0);
        chk("rst_we", o_regWrite_en, 0);
        chk("rst_addr", o_write_addr, 0);
        chk("rst_data", o_write_reg_data, 0);
        chk("rst_busy", o_busy_bits, 0);
        i_rst = 1'b0; i_alu_valid = 1'b0;
        tick();

        // 1: single ALU write, one-cycle latency
        i_alu_valid = 1'b1; i_alu_addr = 5'd16; i_alu_data = 64'd42069;
        #1;
        chk("t1_alu_ready", o_alu_ready, 1);
        chk("t1_mem_ready", o_mem_ready, 0);
        tick();
        i_alu_valid = 1'b0;
        chk("t1_we", o_regWrite_en, 1);
        chk("t1_addr", o_write_addr, 16);
        chk("t1_data", o_write_reg_data, 64'd42069);
        tick();
        chk("t1_we_off", o_regWrite_en, 0);

        // 3: issue to 16, then MEM writes 16 (leaves last_grant = MEM)
        i_issue_valid = 1'b1; i_issue_addr = 5'd16; i_read_1_addr = 5'd16; i_read_2_addr = 5'd2;
        #1;
        chk("t3_no_bypass", o_rd1_busy, 0);
        tick();
        i_issue_valid = 1'b0;
        chk("t3_rd1_busy", o_rd1_busy, 1);
        chk("t3_rd2_busy", o_rd2_busy, 0);
        chk("t3_bits", o_busy_bits, 32'h0001_0000);
        i_mem_valid = 1'b1; i_mem_addr = 5'd16; i_mem_data = 64'hDEAD;
        #1;
        chk("t3_mem_ready", o_mem_ready, 1);
        tick();
        i_mem_valid = 1'b0;
        chk("t3_we", o_regWrite_en, 1);
        chk("t3_busy_n1", o_rd1_busy, 1);
        tick();
        chk("t3_busy_n2", o_rd1_busy, 0);

        // 2: contention alternates ALU, MEM, ALU, MEM
        i_alu_valid = 1'b1; i_alu_addr = 5'd3; i_alu_data = 64'h33;
        i_mem_valid = 1'b1; i_mem_addr = 5'd4; i_mem_data = 64'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t2_alu_ready%0d", k), o_alu_ready, (k % 2 == 0));
            chk($sformatf("t2_mem_ready%0d", k), o_mem_ready, (k % 2 == 1));
            if (k > 0) chk($sformatf("t2_addr%0d", k), o_write_addr, (k % 2 == 1) ? 3 : 4);
            tick();
        end
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        chk("t2_addr_last", o_write_addr, 4);
        chk("t2_data_last", o_write_reg_data, 64'h44);
        tick();

        // 4: issue to 16, then commit of 16 coincides with a new issue to 16
        i_issue_valid = 1'b1; i_issue_addr = 5'd16;
        tick();
        i_issue_valid = 1'b0;
        i_alu_valid = 1'b1; i_alu_addr = 5'd16; i_alu_data = 64'h16;
        tick();
        i_alu_valid = 1'b0;
        i_issue_valid = 1'b1; i_issue_addr = 5'd16;
        chk("t4_we", o_regWrite_en, 1);
        tick();
        i_issue_valid = 1'b0;
        chk("t4_set_wins", o_busy_bits, 32'h0001_0000);

        // 5: write and issue to register 0
        i_alu_valid = 1'b1; i_alu_addr = 5'd0; i_alu_data = 64'd7;
        #1;
        chk("t5_alu_ready", o_alu_ready, 1);
        tick();
        i_alu_valid = 1'b0;
        chk("t5_we", o_regWrite_en, 0);
        chk("t5_bits", o_busy_bits, 32'h0001_0000);
        i_issue_valid = 1'b1; i_issue_addr = 5'd0;
        tick();
        i_issue_valid = 1'b0;
        chk("t5_bit0", o_busy_bits, 32'h0001_0000);
        // The reg-0 ALU grant counts for round-robin: MEM wins next
        i_alu_valid = 1'b1; i_alu_addr = 5'd8; i_alu_data = 64'h8;
        i_mem_valid = 1'b1; i_mem_addr = 5'd9; i_mem_data = 64'h9;
        #1;
        chk("t5_rr_mem", o_mem_ready, 1);
        chk("t5_rr_alu", o_alu_ready, 0);
        tick();
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        chk("t5_rr_addr", o_write_addr, 9);

        // 6: reset during back-to-back writes with busy = 0x00010008
        i_issue_valid = 1'b1; i_issue_addr = 5'd3;
        i_alu_valid = 1'b1; i_alu_addr = 5'd20; i_alu_data = 64'h20;
        tick();
        i_issue_valid = 1'b0;
        i_alu_addr = 5'd21; i_alu_data = 64'h21;
        chk("t6_bits", o_busy_bits, 32'h0001_0008);
        chk("t6_we", o_regWrite_en, 1);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_ready", o_alu_ready, 0);
        tick();
        i_rst = 1'b0;
        chk("t6_we_rst", o_regWrite_en, 0);
        chk("t6_busy_rst", o_busy_bits, 0);
        chk("t6_addr_rst", o_write_addr, 0);
        i_mem_valid = 1'b1; i_mem_addr = 5'd22; i_mem_data = 64'h22;
        #1;
        chk("t6_first_alu", o_alu_ready, 1);
        chk("t6_first_mem", o_mem_ready, 0);
        tick();
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        chk("t6_wb_addr", o_write_addr, 21);
        chk("t6_wb_data", o_write_reg_data, 64'h21);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
